mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Iterative HI/LO multiply/divide unit for the MIPS datapath. Sits directly
//   downstream of the register file and takes RD1/RD2 as SrcA/SrcB.
//   Runs MULT/MULTU/DIV/DIVU over WIDTH+1 cycles and holds results in HI/LO.
//   Also accepts MTHI/MTLO writes. Busy drives the pipeline stall logic.
// PARAMETERS
//   WIDTH  32  operand width; HI/LO each WIDTH bits; op latency WIDTH+1 cycles
// PORTS
//   clk    in   1      clock, all state updates on rising edge
//   reset  in   1      asynchronous, active-high reset
//   Start  in   1      launch op; sampled only in IDLE
//   Op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcA   in   WIDTH  multiplicand / dividend (register file RD1)
//   SrcB   in   WIDTH  multiplier / divisor (register file RD2)
//   HIWE   in   1      MTHI write enable
//   LOWE   in   1      MTLO write enable
//   WD     in   WIDTH  MTHI/MTLO write data
//   Busy   out  1      op in progress (CALC or SIGN)
//   Done   out  1      one-cycle pulse, HI/LO just updated by an op
//   HI     out  WIDTH  HI register (product upper half / remainder)
//   LO     out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, count=0, HI=LO=0, Busy=0, Done=0.
//   FSM: IDLE -> CALC -> SIGN -> IDLE.
//   - IDLE, edge with Start=1: latch Op, |SrcA|, |SrcB| and result signs.
//     Signed ops use magnitudes; unsigned ops use raw values.
//     Clear count. Next state CALC.
//   - CALC: one shift-add (multiply) or restoring shift-subtract (divide)
//     step per edge. count increments. After WIDTH edges, go to SIGN.
//   - SIGN: one edge. Negate product if operand signs differ (MULT).
//     For DIV: negate quotient if signs differ; remainder takes dividend sign.
//     Write HI/LO, go to IDLE, and assert Done for the following cycle only.
//   Latency: Start sampled at edge E0 -> HI/LO valid and Done=1 after edge
//     E(WIDTH+1); E33 when WIDTH=32. Busy=1 from after E0 until edge E33.
//   Busy is a registered function of state; Done is registered.
//   Start while Busy: ignored, not queued. Operands read only at E0.
//   HI/LO hold their previous values throughout CALC. Results become visible
//     only in the SIGN update.
//   Divide by zero: HI=SrcA as latched, LO=all ones. Applies to DIV and DIVU,
//     regardless of signs. Takes the full latency.
//   DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
//   HIWE/LOWE: in IDLE, write WD to HI/LO at the edge (both may assert
//     together). Ignored while Busy. No effect on the SIGN-edge write.
//   Start and HIWE/LOWE on the same IDLE edge: the MT write takes effect.
//     The op then starts and later overwrites HI/LO.
//   Reset mid-op: aborts immediately. No Done. HI/LO=0.
// TESTING
//   MULT 7 x 0xFFFFFFFD -> Done at E33, HI=0xFFFFFFFF, LO=0xFFFFFFEB,
//     Busy high for exactly 33 cycles.
//   MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//   DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//   DIVU 100 / 0 -> HI=0x64, LO=0xFFFFFFFF.
//   Start and HIWE pulsed at cycle 5 of an active op -> both ignored, original
//     result lands at E33.
//   Reset asserted at cycle 10 of an op -> Busy=0, HI=LO=0 at once, no Done.
//     A new MULT 3 x 4 then gives LO=12.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the pipeline and the HI/LO multiply/divide unit
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             HIWE;
    logic             LOWE;
    logic [WIDTH-1:0] WD;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, SrcA, SrcB, HIWE, LOWE, WD,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, SrcA, SrcB, HIWE, LOWE, WD,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    mult_div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic                 busy_q, busy_d, done_q, done_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     q_fin, r_fin;

    // Op[0] set means unsigned, so signs only matter when it is clear.
    assign a_neg    = ~bus.Op[0] & bus.SrcA[WIDTH-1];
    assign b_neg    = ~bus.Op[0] & bus.SrcB[WIDTH-1];
    assign a_mag    = a_neg ? -bus.SrcA : bus.SrcA;
    assign b_mag    = b_neg ? -bus.SrcB : bus.SrcB;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, b_q};
    assign div_ok   = ~div_diff[WIDTH];

    assign prod     = neg_res_q ? -acc_q : acc_q;
    assign q_fin    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign r_fin    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.HIWE) hi_d = bus.WD;
                if (bus.LOWE) lo_d = bus.WD;
                if (bus.Start) begin
                    op_d      = bus.Op;
                    // Divide keeps the raw dividend for the divide-by-zero result.
                    a_d       = bus.Op[1] ? bus.SrcA : a_mag;
                    b_d       = b_mag;
                    acc_d     = bus.Op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    count_d   = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                count_d = count_q + CW'(1);
                if (op_q[1])
                    acc_d = {(div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ok};
                else
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                if (count_q == CW'(WIDTH - 1)) state_d = S_SIGN;
            end
            S_SIGN: begin
                if (op_q[1]) begin
                    if (b_q == '0) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = r_fin;
                        lo_d = q_fin;
                    end
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_SIGN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule
